dmem_port_arbiter: RTL and testbench

- Shares the single-port DataMemory between two requesters.
- Port 0 is the pipeline MEM stage; port 1 is the secondary master (program loader / debug).
- Serialises accesses, drives the memory's memRead/memWrite/address/writeData, and captures readData.
- Returns per-port ack plus a stall for the pipeline, so DataMemory never sees two masters in the same cycle.

---
 rtl/dmem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter in front of the single-port DataMemory.
// Port 0 is the pipeline MEM stage, port 1 the loader/debug master.
// One access is in flight at a time: IDLE -> BUSY (LATENCY cycles) -> DONE,
// or IDLE -> DONE directly for an out-of-range address.
//
// Handshake: a requester raises reqN and holds it (along with weN/addrN/wdataN)
// until the grant edge; the arbiter samples the command at grant, and later
// pulses ackN for exactly one cycle with rdataN/errN valid in that same cycle.
// reqN may drop any time after grant; the access always runs to its ack.
module dmem_port_arbiter #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 1024,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          stall0,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [AW:0] DEPTH_W  = (AW + 1)'(DEPTH);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          last;
    logic          gid;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          err_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          gnt_any;
    logic          gnt_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_oor;

    // Round-robin pick: on a tie the port that was not served last wins.
    always_comb begin
        gnt_any   = req0 | req1;
        gnt_id    = (req0 & req1) ? ~last : ~req0;
        sel_we    = gnt_id ? we1 : we0;
        sel_addr  = gnt_id ? addr1 : addr0;
        sel_wdata = gnt_id ? wdata1 : wdata0;
        sel_oor   = {1'b0, sel_addr} >= DEPTH_W;
    end

    // Access sequencer: grant/latch, count memory cycles, capture read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            last     <= 1'b1;
            gid      <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        gid     <= gnt_id;
                        last    <= gnt_id;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        err_q   <= sel_oor;
                        if (sel_oor) begin
                            // Rejected access reports zero data alongside err.
                            if (gnt_id) rdata1_q <= '0;
                            else        rdata0_q <= '0;
                            state <= DONE;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (gid) rdata1_q <= we_q ? '0 : mem_rdata;
                        else     rdata0_q <= we_q ? '0 : mem_rdata;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes and per-port responses decoded from the current state.
    always_comb begin
        mem_read  = (state == BUSY) & ~we_q;
        mem_write = (state == BUSY) & we_q & (cnt == CNT_INIT);
        mem_addr  = (state == BUSY) ? addr_q : '0;
        mem_wdata = (state == BUSY) ? wdata_q : '0;
        ack0      = (state == DONE) & ~gid;
        ack1      = (state == DONE) & gid;
        err0      = ack0 & err_q;
        err1      = ack1 & err_q;
        stall0    = req0 & ~ack0;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed cases followed by randomized rounds
// checked against a transaction-level model (round-robin order, latency
// arithmetic, a reference memory array).
module tb_dmem_port_arbiter;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1, stall0;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  // Stand-in DataMemory: combinational read, write on the rising edge.
  logic [31:0] tb_mem [DEPTH];

  // Transaction model state.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rd [2];
  logic        last_m;
  logic [41:0] exp_q[$];   // {port, err, ack_cycle[7:0], rdata[31:0]}

  int chk_cnt  = 0;
  int pass_cnt = 0;

  dmem_port_arbiter #(.LATENCY(LAT), .DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .stall0(stall0),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr[9:0]] <= mem_wdata;
  end

  assign mem_rdata = tb_mem[mem_addr[9:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Drives one round (either or both ports), predicts the ack order/timing and
  // data from the model, then watches the DUT until every expected ack arrived.
  // Called at a negedge with the DUT idle.
  task automatic run_round(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                           input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    int  order [2];
    int  n;
    int  e;
    int  exp_wr;
    int  exp_rdc;
    int  wcnt;
    int  rcnt;
    int  sbad;
    logic [41:0] item;
    n = 0;
    if (r0 && r1) begin
      order[0] = last_m ? 0 : 1;
      order[1] = last_m ? 1 : 0;
      n = 2;
    end else if (r0) begin
      order[0] = 0; n = 1;
    end else if (r1) begin
      order[0] = 1; n = 1;
    end
    // model: each access starts two cycles after the previous ack
    e = 1; exp_wr = 0; exp_rdc = 0;
    for (int k = 0; k < n; k++) begin
      int p;
      bit w, oor;
      logic [31:0] a, d, rd;
      int ack_e;
      p   = order[k];
      w   = p ? w1 : w0;
      a   = p ? a1 : a0;
      d   = p ? d1 : d0;
      oor = (a >= DEPTH);
      ack_e = e + (oor ? 0 : LAT);
      rd  = (oor || w) ? 32'd0 : ref_mem[a];
      if (!oor && w) begin
        ref_mem[a] = d;
        exp_wr++;
      end
      if (!oor && !w) exp_rdc += LAT;
      exp_rd[p] = rd;
      exp_q.push_back({p[0], oor, 8'(ack_e), rd});
      last_m = p[0];
      e = ack_e + 2;
    end
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    e = 0; wcnt = 0; rcnt = 0; sbad = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e++;
      if (e > 40) begin
        check("ack_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        break;
      end
      if (mem_write) wcnt++;
      if (mem_read)  rcnt++;
      if (stall0 !== (req0 & ~ack0)) sbad++;
      if (ack0 && ack1) check("dual_ack", 64'(1), 64'(0));
      for (int p = 0; p < 2; p++) begin
        logic ak, er;
        logic [31:0] rd_o;
        ak   = p ? ack1 : ack0;
        er   = p ? err1 : err0;
        rd_o = p ? rdata1 : rdata0;
        if (ak) begin
          if (exp_q.size() == 0) begin
            check("spurious_ack", 64'(p), 64'(2));
          end else begin
            item = exp_q.pop_front();
            check("ack_port", 64'(p), 64'(item[41]));
            check("ack_cycle", 64'(e), 64'(item[39:32]));
            check("err", 64'(er), 64'(item[40]));
            check("rdata", 64'(rd_o), 64'(item[31:0]));
          end
          if (p == 0) req0 = 1'b0;
          else        req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("wr_strobes", 64'(wcnt), 64'(exp_wr));
    check("rd_cycles", 64'(rcnt), 64'(exp_rdc));
    check("stall0", 64'(sbad), 64'd0);
    @(negedge clk);
    check("ack_one_cycle", {62'd0, ack0, ack1}, 64'd0);
    check("rdata0_hold", 64'(rdata0), 64'(exp_rd[0]));
    check("rdata1_hold", 64'(rdata1), 64'(exp_rd[1]));
  endtask

  task automatic single(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p) run_round(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, w, a, d);
    else   run_round(1'b1, w, a, d, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    last_m = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {58'd0, ack0, ack1, err0, err1, mem_read, mem_write}, 64'd0);
    check("rst_bus", {mem_addr, mem_wdata}, 64'd0);
    check("rst_rdata", {rdata0, rdata1}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // load addresses 0..15 and the top word through alternating ports
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = (i == 0) ? 32'd15 : (i == 1) ? 32'd25 : (i == 3) ? 32'd80 : $urandom;
      single(i[0], 1'b1, 32'(i), v);
    end
    single(1'b1, 1'b1, 32'd1023, 32'hA5A5_0001);

    // write then read back through port 0
    single(1'b0, 1'b1, 32'd5, 32'h0000_DEAD);
    single(1'b0, 1'b0, 32'd5, 32'd0);

    // ties: round-robin alternation
    run_round(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd1, 32'd0);
    run_round(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd1, 32'd0);

    // port 1 read with multi-cycle latency
    single(1'b1, 1'b0, 32'd3, 32'd0);

    // address range boundaries
    single(1'b0, 1'b0, 32'd1024, 32'd0);
    single(1'b0, 1'b0, 32'd1023, 32'd0);
    single(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
    single(1'b0, 1'b1, 32'd1024, 32'h0BAD_0BAD);

    // reset during the second BUSY cycle of a port-0 read
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
    @(negedge clk);
    @(negedge clk);
    check("busy_read", 64'(mem_read), 64'd1);
    rst = 1'b0;
    req0 = 1'b0;
    #1;
    check("mid_rst_ctl", {58'd0, ack0, ack1, err0, err1, mem_read, mem_write}, 64'd0);
    check("mid_rst_bus", {mem_addr, mem_wdata}, 64'd0);
    check("mid_rst_rdata", {rdata0, rdata1}, 64'd0);
    last_m = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clk);
    check("rst_held_ack", {62'd0, ack0, ack1}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    single(1'b1, 1'b0, 32'd3, 32'd0);
    run_round(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd1, 32'd0);

    // randomized rounds
    for (int r = 0; r < 150; r++) begin
      bit r0, r1, w0, w1;
      logic [31:0] a [2];
      int pick;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      for (int p = 0; p < 2; p++) begin
        pick = $urandom_range(0, 9);
        if (pick == 0)      a[p] = 32'd1023;
        else if (pick == 1) a[p] = DEPTH + $urandom_range(0, 3);
        else                a[p] = 32'($urandom_range(0, 15));
      end
      run_round(r0, w0, a[0], $urandom, r1, w1, a[1], $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
